keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row sense lines in, column strobes and
// decoded key status out.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_valid;

    // Scanner side
    modport master (
        input  row,
        output col,
        output key_code,
        output key_pressed,
        output key_valid
    );

    // Keypad / consumer side
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_pressed,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low column per slot, samples
// the synchronized rows at slot end, resolves a per-scan priority key and
// debounces press/release over whole scans.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    keypad_scanner_if.master   kp
);

    localparam int                CNT_W  = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  TERM   = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DB_MAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RELEASED, DB_PRESS, PRESSED, DB_RELEASE} state_t;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic             acc_vld_q;
    logic [3:0]       acc_code_q;
    state_t           state_q;
    logic [3:0]       cand_q;
    logic [3:0]       count_q;
    logic [3:0]       key_code_q;
    logic             key_pressed_q;
    logic             key_valid_q;

    logic             tick, scan_done, hit, res_vld;
    logic [1:0]       hit_row;
    logic [3:0]       res_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;  4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;  4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;  4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;  4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;  4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;  4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;  4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;  default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Debounce counter never wraps past the acceptance threshold
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= DB_MAX) ? DB_MAX : v + 4'd1;
    endfunction

    // Slot timing, column advance and the resolved scan result
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
        end
        tick      = (slot_q == TERM);
        scan_done = tick && (col_idx_q == 2'd3);
        slot_d    = tick ? '0 : slot_q + CNT_W'(1);
        col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        res_vld   = acc_vld_q || hit;
        res_code  = acc_vld_q ? acc_code_q : key_map(hit_row, col_idx_q);
    end

    // Row synchronizer, slot counter, column strobe and first-hit accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            slot_q     <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            acc_vld_q  <= 1'b0;
            acc_code_q <= 4'h0;
        end else begin
            row_s1_q  <= kp.row;
            row_s2_q  <= row_s1_q;
            slot_q    <= slot_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            if (scan_done) begin
                acc_vld_q <= 1'b0;
            end else if (tick && !acc_vld_q && hit) begin
                acc_vld_q  <= 1'b1;
                acc_code_q <= key_map(hit_row, col_idx_q);
            end
        end
    end

    // Debounce FSM, stepped once per completed scan
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RELEASED;
            cand_q        <= 4'h0;
            count_q       <= 4'd0;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
            key_valid_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                case (state_q)
                    RELEASED: begin
                        if (res_vld) begin
                            cand_q <= res_code;
                            if (4'd1 >= DB_MAX) begin
                                state_q       <= PRESSED;
                                key_code_q    <= res_code;
                                key_pressed_q <= 1'b1;
                                key_valid_q   <= 1'b1;
                                count_q       <= 4'd0;
                            end else begin
                                state_q <= DB_PRESS;
                                count_q <= 4'd1;
                            end
                        end
                    end
                    DB_PRESS: begin
                        if (!res_vld) begin
                            state_q <= RELEASED;
                            count_q <= 4'd0;
                        end else if (res_code != cand_q) begin
                            cand_q  <= res_code;
                            count_q <= 4'd1;
                        end else if (sat_inc(count_q) >= DB_MAX) begin
                            state_q       <= PRESSED;
                            key_code_q    <= cand_q;
                            key_pressed_q <= 1'b1;
                            key_valid_q   <= 1'b1;
                            count_q       <= 4'd0;
                        end else begin
                            count_q <= sat_inc(count_q);
                        end
                    end
                    PRESSED: begin
                        if (!(res_vld && res_code == key_code_q)) begin
                            state_q <= DB_RELEASE;
                            count_q <= 4'd1;
                            if (4'd1 >= DB_MAX) begin
                                key_pressed_q <= 1'b0;
                                // The scan that completes a release does not count toward the next press
                                state_q <= res_vld ? DB_PRESS : RELEASED;
                                cand_q  <= res_code;
                                count_q <= 4'd0;
                            end
                        end
                    end
                    default: begin // DB_RELEASE
                        if (res_vld && res_code == key_code_q) begin
                            state_q <= PRESSED;
                            count_q <= 4'd0;
                        end else if (sat_inc(count_q) >= DB_MAX) begin
                            key_pressed_q <= 1'b0;
                            state_q       <= res_vld ? DB_PRESS : RELEASED;
                            cand_q        <= res_code;
                            count_q       <= 4'd0;
                        end else begin
                            count_q <= sat_inc(count_q);
                        end
                    end
                endcase
            end
        end
    end

    assign kp.col         = col_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_pressed = key_pressed_q;
    assign kp.key_valid   = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2: a
// behavioural keypad matrix drives the rows and a scoreboard of expected
// accepted keys is matched against every key_valid pulse.
module tb_keypad_scanner;

    localparam int SCAN_CYC = 16;

    logic        clk;
    logic        reset_n;
    logic [15:0] keys;      // bit r*4+c = key at row r, column c held
    logic [3:0]  rowv;
    logic [3:0]  exp_q[$];
    logic        prev_valid;
    int          n_asserts;
    int          n_fail;
    int          n_valid;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a row is pulled low when a held key sits on the strobed column
    always_comb begin
        rowv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col[c]) rowv[r] = 1'b0;
    end
    assign kp.row = rowv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (SCAN_CYC * n) @(negedge clk);
    endtask

    // Scoreboard consumer: every key_valid must match the next queued key
    always @(negedge clk) begin
        logic pend;
        if (kp.key_valid === 1'b1) begin
            n_valid++;
            chk("valid_with_pressed", kp.key_pressed, 1);
            chk("valid_single_cycle", prev_valid, 0);
            pend = (exp_q.size() != 0);
            chk("valid_expected", pend, 1);
            if (pend) chk("valid_key_code", kp.key_code, exp_q.pop_front());
        end
        prev_valid = kp.key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ec;
        n_asserts  = 0;
        n_fail     = 0;
        n_valid    = 0;
        prev_valid = 1'b0;
        keys       = 16'h0;
        reset_n    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_col", kp.col, 4'b1110);
        chk("rst_code", kp.key_code, 4'h0);
        chk("rst_pressed", kp.key_pressed, 0);
        chk("rst_valid", kp.key_valid, 0);
        reset_n = 1'b1;

        // Idle scanning: column strobe pattern over 10 scans
        for (int i = 1; i <= 10 * SCAN_CYC; i++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((i / 4) % 4));
            chk("idle_col", kp.col, ec);
        end
        chk("idle_pressed", kp.key_pressed, 0);

        // Key '5' held then released
        keys = 16'h0020;
        exp_q.push_back(4'h5);
        wait_scans(1);
        chk("k5_scan1_pressed", kp.key_pressed, 0);
        wait_scans(1);
        chk("k5_pressed", kp.key_pressed, 1);
        chk("k5_code", kp.key_code, 4'h5);
        keys = 16'h0;
        wait_scans(1);
        chk("k5_rel1_pressed", kp.key_pressed, 1);
        wait_scans(1);
        chk("k5_rel2_pressed", kp.key_pressed, 0);
        chk("k5_code_held", kp.key_code, 4'h5);

        // Key '9' bounce for one scan
        keys = 16'h0400;
        wait_scans(1);
        keys = 16'h0;
        wait_scans(3);
        chk("k9_bounce_pressed", kp.key_pressed, 0);
        chk("k9_bounce_code", kp.key_code, 4'h5);

        // '2' and 'D' together, then '2' released with 'D' still held
        keys = 16'h8002;
        exp_q.push_back(4'h2);
        wait_scans(2);
        chk("k2d_pressed", kp.key_pressed, 1);
        chk("k2d_code", kp.key_code, 4'h2);
        keys = 16'h8000;
        exp_q.push_back(4'hD);
        wait_scans(1);
        chk("kd_rel1_pressed", kp.key_pressed, 1);
        wait_scans(1);
        chk("kd_rel2_pressed", kp.key_pressed, 0);
        chk("kd_rel2_code", kp.key_code, 4'h2);
        wait_scans(1);
        chk("kd_db1_pressed", kp.key_pressed, 0);
        wait_scans(1);
        chk("kd_pressed", kp.key_pressed, 1);
        chk("kd_code", kp.key_code, 4'hD);
        keys = 16'h0;
        wait_scans(2);
        chk("kd_released", kp.key_pressed, 0);

        // Key '7' with a one-scan dropout
        keys = 16'h0100;
        exp_q.push_back(4'h7);
        wait_scans(2);
        chk("k7_pressed", kp.key_pressed, 1);
        chk("k7_code", kp.key_code, 4'h7);
        keys = 16'h0;
        wait_scans(1);
        keys = 16'h0100;
        wait_scans(2);
        chk("k7_dropout_pressed", kp.key_pressed, 1);

        // Asynchronous reset mid-press, then re-acceptance
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_col", kp.col, 4'b1110);
        chk("arst_pressed", kp.key_pressed, 0);
        chk("arst_code", kp.key_code, 4'h0);
        chk("arst_valid", kp.key_valid, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(4'h7);
        wait_scans(1);
        chk("re7_scan1_pressed", kp.key_pressed, 0);
        wait_scans(1);
        chk("re7_pressed", kp.key_pressed, 1);
        chk("re7_code", kp.key_code, 4'h7);
        wait_scans(1);

        chk("valid_count", n_valid, 5);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
